// File: rtl/lcd_timing_gen.sv
// Raster timing generator for a 480x272 parallel-RGB LCD panel.
// Produces sync, data-enable, pixel/line coordinates and a slow strobe.
module lcd_timing_gen #(
    parameter int unsigned H_SYNC      = 41,
    parameter int unsigned H_BP        = 2,
    parameter int unsigned H_ACTIVE    = 480,
    parameter int unsigned H_FP        = 2,
    parameter int unsigned V_SYNC      = 10,
    parameter int unsigned V_BP        = 2,
    parameter int unsigned V_ACTIVE    = 272,
    parameter int unsigned V_FP        = 2,
    parameter int unsigned SLOW_FRAMES = 10
) (
    input  logic       clk9MHz,
    input  logic       reset_n,
    output logic       hSync,
    output logic       vSync,
    output logic       hData,
    output logic       vData,
    output logic       disp,
    output logic [9:0] vgaCount,
    output logic [8:0] lineCount,
    output logic       frameTick,
    output logic       clk3Hz
);

    localparam int unsigned H_TOT = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int unsigned V_TOT = V_SYNC + V_BP + V_ACTIVE + V_FP;

    localparam logic [9:0] H_LAST    = 10'(H_TOT - 1);
    localparam logic [9:0] H_SYNC_E  = 10'(H_SYNC);
    localparam logic [9:0] H_ACT_BEG = 10'(H_SYNC + H_BP);
    localparam logic [9:0] H_ACT_END = 10'(H_SYNC + H_BP + H_ACTIVE);

    localparam logic [8:0] V_LAST    = 9'(V_TOT - 1);
    localparam logic [8:0] V_SYNC_E  = 9'(V_SYNC);
    localparam logic [8:0] V_ACT_BEG = 9'(V_SYNC + V_BP);
    localparam logic [8:0] V_ACT_END = 9'(V_SYNC + V_BP + V_ACTIVE);

    // A single-frame half-period still needs a one-bit counter.
    localparam int unsigned FW = (SLOW_FRAMES > 1) ? $clog2(SLOW_FRAMES) : 1;
    localparam logic [FW-1:0] F_LAST = FW'(SLOW_FRAMES - 1);

    logic [9:0]    h_cnt;
    logic [8:0]    v_cnt;
    logic [FW-1:0] frame_cnt;
    logic          h_wrap;
    logic          v_wrap;

    assign h_wrap = (h_cnt == H_LAST);
    assign v_wrap = (v_cnt == V_LAST);

    // Pixel counter: runs every clock, wraps at end of line.
    always_ff @(posedge clk9MHz or negedge reset_n) begin
        if (!reset_n) begin
            h_cnt <= '0;
        end else if (h_wrap) begin
            h_cnt <= '0;
        end else begin
            h_cnt <= h_cnt + 10'd1;
        end
    end

    // Line counter: advances only when the pixel counter wraps.
    always_ff @(posedge clk9MHz or negedge reset_n) begin
        if (!reset_n) begin
            v_cnt <= '0;
        end else if (h_wrap) begin
            if (v_wrap) begin
                v_cnt <= '0;
            end else begin
                v_cnt <= v_cnt + 9'd1;
            end
        end
    end

    // Decode straight from the counters so outputs carry no extra latency.
    assign hSync     = (h_cnt >= H_SYNC_E);
    assign vSync     = (v_cnt >= V_SYNC_E);
    assign hData     = (h_cnt >= H_ACT_BEG) && (h_cnt < H_ACT_END);
    assign vData     = (v_cnt >= V_ACT_BEG) && (v_cnt < V_ACT_END);
    assign vgaCount  = hData ? (h_cnt - H_ACT_BEG) : '0;
    assign lineCount = vData ? (v_cnt - V_ACT_BEG) : '0;
    assign frameTick = h_wrap && v_wrap;

    // Frame divider: clk3Hz flips every SLOW_FRAMES frames.
    always_ff @(posedge clk9MHz or negedge reset_n) begin
        if (!reset_n) begin
            frame_cnt <= '0;
            clk3Hz    <= 1'b0;
        end else if (frameTick) begin
            if (frame_cnt == F_LAST) begin
                frame_cnt <= '0;
                clk3Hz    <= ~clk3Hz;
            end else begin
                frame_cnt <= frame_cnt + FW'(1);
            end
        end
    end

    // Panel enable latches high on the first clock out of reset.
    always_ff @(posedge clk9MHz or negedge reset_n) begin
        if (!reset_n) begin
            disp <= 1'b0;
        end else begin
            disp <= 1'b1;
        end
    end

endmodule

// File: tb/tb_lcd_timing_gen.sv
// Testbench for lcd_timing_gen: default, mid-size and tiny timings.
// Reference model derives counters from clocks elapsed since release.
module tb_lcd_timing_gen;

    typedef struct packed {
        logic       hs;
        logic       vs;
        logic       hd;
        logic       vd;
        logic       ft;
        logic [9:0] vga;
        logic [8:0] ln;
    } out_t;

    typedef struct {
        int hs, hb, ha, hf, vs, vb, va, vf;
    } tim_t;

    typedef struct {
        int         ln;
        int         col;
        logic [4:0] flags;
        int         vga;
        int         lc;
        string      nm;
    } vec_t;

    logic clk;
    logic rd_n, rm_n, rs_n;

    logic       d_hs, d_vs, d_hd, d_vd, d_disp, d_ft, d_c3;
    logic [9:0] d_vga;
    logic [8:0] d_ln;
    logic       m_hs, m_vs, m_hd, m_vd, m_disp, m_ft, m_c3;
    logic [9:0] m_vga;
    logic [8:0] m_ln;
    logic       s_hs, s_vs, s_hd, s_vd, s_disp, s_ft, s_c3;
    logic [9:0] s_vga;
    logic [8:0] s_ln;

    out_t act [3];
    logic disp_a [3];
    logic c3_a [3];

    tim_t tp [3];
    int   n_cnt [3];
    out_t sb_q [$];
    int   sb_err;
    int   tests;
    int   fails;
    vec_t vt [14];

    lcd_timing_gen u_def (
        .clk9MHz(clk), .reset_n(rd_n),
        .hSync(d_hs), .vSync(d_vs), .hData(d_hd), .vData(d_vd),
        .disp(d_disp), .vgaCount(d_vga), .lineCount(d_ln),
        .frameTick(d_ft), .clk3Hz(d_c3)
    );

    lcd_timing_gen #(
        .H_SYNC(4), .H_BP(2), .H_ACTIVE(20), .H_FP(2),
        .V_SYNC(3), .V_BP(2), .V_ACTIVE(10), .V_FP(2),
        .SLOW_FRAMES(10)
    ) u_mid (
        .clk9MHz(clk), .reset_n(rm_n),
        .hSync(m_hs), .vSync(m_vs), .hData(m_hd), .vData(m_vd),
        .disp(m_disp), .vgaCount(m_vga), .lineCount(m_ln),
        .frameTick(m_ft), .clk3Hz(m_c3)
    );

    lcd_timing_gen #(
        .H_SYNC(1), .H_BP(1), .H_ACTIVE(4), .H_FP(1),
        .V_SYNC(1), .V_BP(1), .V_ACTIVE(2), .V_FP(1),
        .SLOW_FRAMES(1)
    ) u_sml (
        .clk9MHz(clk), .reset_n(rs_n),
        .hSync(s_hs), .vSync(s_vs), .hData(s_hd), .vData(s_vd),
        .disp(s_disp), .vgaCount(s_vga), .lineCount(s_ln),
        .frameTick(s_ft), .clk3Hz(s_c3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Gather each instance's outputs for indexed access.
    always_comb begin
        act[0]    = {d_hs, d_vs, d_hd, d_vd, d_ft, d_vga, d_ln};
        act[1]    = {m_hs, m_vs, m_hd, m_vd, m_ft, m_vga, m_ln};
        act[2]    = {s_hs, s_vs, s_hd, s_vd, s_ft, s_vga, s_ln};
        disp_a[0] = d_disp;
        disp_a[1] = m_disp;
        disp_a[2] = s_disp;
        c3_a[0]   = d_c3;
        c3_a[1]   = m_c3;
        c3_a[2]   = s_c3;
    end

    function automatic out_t model(input tim_t t, input int n);
        out_t o;
        int ht, vt_, hc, vc, hb, vb;
        ht  = t.hs + t.hb + t.ha + t.hf;
        vt_ = t.vs + t.vb + t.va + t.vf;
        hc  = n % ht;
        vc  = (n / ht) % vt_;
        hb  = t.hs + t.hb;
        vb  = t.vs + t.vb;
        o.hs  = (hc >= t.hs);
        o.vs  = (vc >= t.vs);
        o.hd  = (hc >= hb) && (hc < hb + t.ha);
        o.vd  = (vc >= vb) && (vc < vb + t.va);
        o.ft  = (hc == ht - 1) && (vc == vt_ - 1);
        o.vga = o.hd ? 10'(hc - hb) : 10'd0;
        o.ln  = o.vd ? 9'(vc - vb) : 9'd0;
        return o;
    endfunction

    function automatic logic [25:0] pack_all(input int k);
        return {act[k], disp_a[k], c3_a[k]};
    endfunction

    task automatic chk(input string nm, input logic [31:0] a,
                       input logic [31:0] e);
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, a, e);
        end
    endtask

    // Push the expectation for the coming clock, then pop it at the sample.
    task automatic step(input int k);
        out_t e;
        sb_q.push_back(model(tp[k], n_cnt[k] + 1));
        @(posedge clk);
        @(negedge clk);
        #1;
        n_cnt[k]++;
        e = sb_q.pop_front();
        if (act[k] !== e) sb_err++;
    endtask

    task automatic do_release(input int k);
        @(negedge clk);
        case (k)
            0:       rd_n = 1'b1;
            1:       rm_n = 1'b1;
            default: rs_n = 1'b1;
        endcase
        n_cnt[k] = 0;
        #1;
        if (act[k] !== model(tp[k], 0)) sb_err++;
    endtask

    initial begin
        int idx, vsl, hv, ticks, tog, bad, last;
        int hf1, hf2, vf1, vf2;
        logic prev_ft, prev_c3, prev_hs, prev_vs;
        logic [23:0] av, ev;

        rd_n = 1'b0; rm_n = 1'b0; rs_n = 1'b0;
        tests = 0; fails = 0; sb_err = 0;
        tp[0] = '{41, 2, 480, 2, 10, 2, 272, 2};
        tp[1] = '{4, 2, 20, 2, 3, 2, 10, 2};
        tp[2] = '{1, 1, 4, 1, 1, 1, 2, 1};

        // flags = {hSync, vSync, hData, vData, disp}
        vt[0]  = '{0,   0, 5'b00000,   0, 0, "def_reset_state"};
        vt[1]  = '{0,   1, 5'b00001,   0, 0, "def_disp_after_1clk"};
        vt[2]  = '{0,  40, 5'b00001,   0, 0, "def_hsync_low_40"};
        vt[3]  = '{0,  41, 5'b10001,   0, 0, "def_hsync_rise_41"};
        vt[4]  = '{0,  43, 5'b10101,   0, 0, "def_hdata_line0"};
        vt[5]  = '{0, 524, 5'b10001,   0, 0, "def_hcnt_524"};
        vt[6]  = '{1,   0, 5'b00001,   0, 0, "def_hcnt_wrap"};
        vt[7]  = '{10,  0, 5'b01001,   0, 0, "def_vsync_rise"};
        vt[8]  = '{11, 43, 5'b11101,   0, 0, "def_line11_no_vdata"};
        vt[9]  = '{12, 42, 5'b11011,   0, 0, "def_l12_h42"};
        vt[10] = '{12, 43, 5'b11111,   0, 0, "def_l12_hdata_rise"};
        vt[11] = '{12,100, 5'b11111,  57, 0, "def_l12_vga57"};
        vt[12] = '{12,522, 5'b11111, 479, 0, "def_l12_vga479"};
        vt[13] = '{12,523, 5'b11011,   0, 0, "def_l12_hdata_fall"};

        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_def_all", 32'(pack_all(0)), 0);
        chk("rst_mid_all", 32'(pack_all(1)), 0);
        chk("rst_sml_all", 32'(pack_all(2)), 0);

        // Default timing: table vectors over the first 13 lines.
        do_release(0);
        idx = 0;
        vsl = 0;
        for (int n = 0; n <= 12 * 525 + 524; n++) begin
            if (n > 0) step(0);
            if (d_vs === 1'b0) vsl++;
            if (idx < 14 && vt[idx].ln * 525 + vt[idx].col == n) begin
                av = {d_hs, d_vs, d_hd, d_vd, d_disp, d_vga, d_ln};
                ev = {vt[idx].flags, 10'(vt[idx].vga), 9'(vt[idx].lc)};
                chk(vt[idx].nm, 32'(av), 32'(ev));
                idx++;
            end
        end
        chk("def_vsync_low_clocks", vsl, 5250);
        chk("def_stream", sb_err, 0);
        sb_err = 0;

        // Mid timing: 28x17 frame of 476 clocks, 50 frames then reset.
        do_release(1);
        ticks = 0; tog = 0; bad = 0; hv = 0; vsl = 0;
        prev_ft = 1'b0; prev_c3 = 1'b0;
        for (int n = 0; n <= 24100; n++) begin
            if (n > 0) step(1);
            if (n == 1) chk("mid_disp_1clk", m_disp, 1);
            if (n < 476 && m_hd && m_vd) hv++;
            if (n < 476 && !m_vs) vsl++;
            if (m_c3 !== prev_c3) begin
                tog++;
                if (!prev_ft || (ticks % 10) != 0) bad++;
            end
            if (prev_ft && (ticks % 10) == 0 && ticks <= 40)
                chk($sformatf("mid_c3_frame%0d", ticks), m_c3,
                    32'((ticks / 10) % 2));
            if (n == 398) chk("mid_last_line_lc", m_ln, 9);
            if (n == 417) chk("mid_last_col_vga", m_vga, 19);
            if (m_ft) begin
                ticks++;
                if (ticks == 1) chk("mid_first_tick", n, 475);
            end
            prev_ft = m_ft;
            prev_c3 = m_c3;
        end
        chk("mid_active_pixels", hv, 200);
        chk("mid_vsync_low_clocks", vsl, 84);
        chk("mid_tick_count", ticks, 50);
        chk("mid_c3_toggles", tog, 5);
        chk("mid_c3_bad_toggles", bad, 0);
        chk("mid_stream", sb_err, 0);
        sb_err = 0;

        chk("mid_pre_reset", 32'(pack_all(1)),
            32'({model(tp[1], 24100), 2'b11}));
        #2;
        rm_n = 1'b0;
        #1;
        chk("mid_async_reset", 32'(pack_all(1)), 0);
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("mid_reset_held", 32'(pack_all(1)), 0);

        do_release(1);
        ticks = 0; tog = 0; bad = 0;
        prev_ft = 1'b0; prev_c3 = 1'b0;
        for (int n = 0; n <= 4760; n++) begin
            if (n > 0) step(1);
            if (m_c3 !== prev_c3) begin
                tog++;
                if (!prev_ft || (ticks % 10) != 0) bad++;
            end
            if (m_ft) begin
                ticks++;
                if (ticks == 1) chk("mid_rel_first_tick", n, 475);
            end
            prev_ft = m_ft;
            prev_c3 = m_c3;
        end
        chk("mid_rel_c3_toggles", tog, 1);
        chk("mid_rel_c3_bad", bad, 0);
        chk("mid_rel_c3_level", m_c3, 1);
        chk("mid_rel_stream", sb_err, 0);
        sb_err = 0;

        // Tiny timing: 7x5 frame, clk3Hz flips every frame.
        do_release(2);
        ticks = 0; last = 0;
        hf1 = -1; hf2 = -1; vf1 = -1; vf2 = -1;
        prev_ft = 1'b0; prev_hs = s_hs; prev_vs = s_vs;
        for (int n = 0; n <= 105; n++) begin
            if (n > 0) step(2);
            if (prev_ft)
                chk($sformatf("sml_c3_tick%0d", ticks), s_c3,
                    32'(ticks % 2));
            if (prev_hs && !s_hs) begin
                if (hf1 < 0) hf1 = n;
                else if (hf2 < 0) hf2 = n;
            end
            if (prev_vs && !s_vs) begin
                if (vf1 < 0) vf1 = n;
                else if (vf2 < 0) vf2 = n;
            end
            if (s_ft) begin
                ticks++;
                if (ticks == 1) chk("sml_first_tick", n, 34);
                else chk("sml_tick_period", n - last, 35);
                last = n;
            end
            prev_ft = s_ft;
            prev_hs = s_hs;
            prev_vs = s_vs;
        end
        chk("sml_htot", hf2 - hf1, 7);
        chk("sml_vtot_clocks", vf2 - vf1, 35);
        chk("sml_tick_count", ticks, 3);
        chk("sml_stream", sb_err, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/lcd_timing_gen.md
LCD_TIMING_GEN -- requirements
Module: lcd_timing_gen

Parameters
REQ-001 The block SHALL have parameter H_SYNC, default 41: hSync low width in pixel clocks.
REQ-002 The block SHALL have parameter H_BP, default 2: horizontal back porch in clocks.
REQ-003 The block SHALL have parameter H_ACTIVE, default 480: visible pixels per line.
REQ-004 The block SHALL have parameter H_FP, default 2: horizontal front porch in clocks.
REQ-005 The block SHALL have parameter V_SYNC, default 10: vSync low width in lines.
REQ-006 The block SHALL have parameter V_BP, default 2: vertical back porch in lines.
REQ-007 The block SHALL have parameter V_ACTIVE, default 272: visible lines per frame.
REQ-008 The block SHALL have parameter V_FP, default 2: vertical front porch in lines.
REQ-009 The block SHALL have parameter SLOW_FRAMES, default 10: frames per clk3Hz half-period.

Interface
REQ-010 The block SHALL have port clk9MHz, input, 1 bit: pixel clock; all state on its rising edge.
REQ-011 The block SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-012 The block SHALL have port hSync, output, 1 bit: horizontal sync, active low.
REQ-013 The block SHALL have port vSync, output, 1 bit: vertical sync, active low.
REQ-014 The block SHALL have port hData, output, 1 bit: high during the active pixel window of a line.
REQ-015 The block SHALL have port vData, output, 1 bit: high during the active line window of a frame.
REQ-016 The block SHALL have port disp, output, 1 bit: LCD display enable.
REQ-017 The block SHALL have port vgaCount, output, 10 bits: active pixel column.
REQ-018 The block SHALL have port lineCount, output, 9 bits: active line row.
REQ-019 The block SHALL have port frameTick, output, 1 bit: one-clock pulse on the last clock of each frame.
REQ-020 The block SHALL have port clk3Hz, output, 1 bit: slow square wave for user-input sampling.

Function
REQ-021 The horizontal counter hCnt (10 bits) SHALL count 0 to H_TOT-1, where H_TOT = H_SYNC+H_BP+H_ACTIVE+H_FP (default 525), then wrap to 0.
REQ-022 The vertical counter vCnt (9 bits) SHALL increment only on the clock where hCnt wraps; it SHALL count 0 to V_TOT-1 (default 286), then wrap to 0 on that same clock.
REQ-023 hSync SHALL be 0 when hCnt < H_SYNC and 1 otherwise; vSync SHALL be 0 when vCnt < V_SYNC and 1 otherwise.
REQ-024 hData SHALL be 1 iff H_SYNC+H_BP <= hCnt < H_SYNC+H_BP+H_ACTIVE (default 43..522).
REQ-025 vData SHALL be 1 iff V_SYNC+V_BP <= vCnt < V_SYNC+V_BP+V_ACTIVE (default 12..283).
REQ-026 vgaCount SHALL equal hCnt-(H_SYNC+H_BP) while hData=1, and 0 otherwise.
REQ-027 lineCount SHALL equal vCnt-(V_SYNC+V_BP) while vData=1, and 0 otherwise.
REQ-028 hSync, vSync, hData, vData, vgaCount and lineCount SHALL be decoded from the current counter registers, with zero clocks of latency relative to hCnt/vCnt.
REQ-029 frameTick SHALL be 1 for exactly one clock, when hCnt=H_TOT-1 and vCnt=V_TOT-1.
REQ-030 A frame counter SHALL increment on each frameTick; on the frameTick where it equals SLOW_FRAMES-1, it SHALL clear to 0 and clk3Hz SHALL toggle (period 20 frames, about 3.0 Hz at 9 MHz).
REQ-031 disp SHALL be a register that goes to 1 on the first rising clock edge after reset_n deasserts and then stays at 1.
REQ-032 The default frame period SHALL be 525*286 = 150150 clocks.

Reset
REQ-033 While reset_n=0, the block SHALL hold hCnt=0, vCnt=0, frame counter=0, clk3Hz=0 and disp=0.
REQ-034 During reset the decoded outputs SHALL therefore be hSync=0, vSync=0, hData=0, vData=0, vgaCount=0, lineCount=0 and frameTick=0.
REQ-035 Asserting reset_n mid-frame SHALL force all of the REQ-033 values immediately, with no clock required.
REQ-036 After reset_n deasserts, counting SHALL restart from hCnt=0, vCnt=0.

Verification
REQ-037 The bench SHALL release reset, then check: disp=1 after 1 clock; hSync=0 for clocks 0..40; hSync rises at hCnt=41; hCnt wraps to 0 after 525 clocks.
REQ-038 The bench SHALL check at line 12: hData rises at hCnt=43 with vgaCount=0 and lineCount=0, and at hCnt=522 vgaCount=479; at line 283 lineCount=271.
REQ-039 The bench SHALL check, over one full frame: vSync=0 for exactly 10*525 = 5250 clocks; frameTick pulses once at clock 150149; the count of clocks with hData=1 and vData=1 equals 480*272 = 130560.
REQ-040 The bench SHALL check over 40 frames that clk3Hz toggles at the end of frames 10, 20, 30 and 40, each edge coincident with frameTick.
REQ-041 The bench SHALL assert reset_n=0 asynchronously at hCnt=300, vCnt=100, and check all outputs take their reset values before the next clock edge; after release, the first frameTick arrives 150150 clocks later.
REQ-042 The bench SHALL set parameters H_ACTIVE=4, V_ACTIVE=2 and all others to 1, then check H_TOT=7, V_TOT=5, and that frameTick repeats every 35 clocks.
